// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: each stage adds one CHUNK-bit slice and registers its carry.
// A global stall (en) freezes every stage; results leave in acceptance order with carry-out and overflow.
module pipe_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             c_i,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_o,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int SAFE_CHUNK = (CHUNK >= 1) ? CHUNK : 1;
  localparam int STAGES     = WIDTH / SAFE_CHUNK;

  generate
    if (CHUNK < 1 || (WIDTH % SAFE_CHUNK) != 0 || STAGES < 1) begin : g_bad_param
      $error("pipe_addsub: WIDTH must be a positive multiple of CHUNK");
    end
  endgenerate

  logic en;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;

  generate
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
      // IN_W: operand bits still to be added on entry; LO: result bits complete on exit.
      localparam int IN_W = WIDTH - gi * CHUNK;
      localparam int LO   = (gi + 1) * CHUNK;

      logic [IN_W-1:0] a_src;
      logic [IN_W-1:0] b_src;
      logic            c_src;
      logic            v_src;
      logic [CHUNK:0]  slice_sum;
      logic [LO-1:0]   s_next;
      logic [LO-1:0]   s_reg;
      logic            c_reg;
      logic            v_reg;

      assign slice_sum = {1'b0, a_src[CHUNK-1:0]}
                       + {1'b0, b_src[CHUNK-1:0]}
                       + {{CHUNK{1'b0}}, c_src};

      if (gi == 0) begin : g_head
        // Subtract as x + ~y + ~c_i.
        assign a_src  = x;
        assign b_src  = sub ? ~y : y;
        assign c_src  = sub ? ~c_i : c_i;
        assign v_src  = in_valid;
        assign s_next = slice_sum[CHUNK-1:0];
      end else begin : g_body
        assign a_src  = g_stage[gi-1].g_skew.a_reg;
        assign b_src  = g_stage[gi-1].g_skew.b_reg;
        assign c_src  = g_stage[gi-1].c_reg;
        assign v_src  = g_stage[gi-1].v_reg;
        assign s_next = {slice_sum[CHUNK-1:0], g_stage[gi-1].s_reg};
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s_reg <= '0;
          c_reg <= 1'b0;
          v_reg <= 1'b0;
        end else if (en) begin
          s_reg <= s_next;
          c_reg <= slice_sum[CHUNK];
          v_reg <= v_src;
        end
      end

      if (gi < STAGES - 1) begin : g_skew
        logic [IN_W-CHUNK-1:0] a_reg;
        logic [IN_W-CHUNK-1:0] b_reg;

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
          end else if (en) begin
            a_reg <= a_src[IN_W-1:CHUNK];
            b_reg <= b_src[IN_W-1:CHUNK];
          end
        end
      end else begin : g_tail
        logic carry_into_msb;
        logic ovf_reg;

        // Sum bit = a ^ b ^ carry_in, so the MSB carry-in is recovered from the slice result.
        assign carry_into_msb = slice_sum[CHUNK-1] ^ a_src[CHUNK-1] ^ b_src[CHUNK-1];

        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ovf_reg <= 1'b0;
          end else if (en) begin
            ovf_reg <= carry_into_msb ^ slice_sum[CHUNK];
          end
        end
      end
    end
  endgenerate

  assign s         = g_stage[STAGES-1].s_reg;
  assign c_o       = g_stage[STAGES-1].c_reg;
  assign out_valid = g_stage[STAGES-1].v_reg;
  assign ovf       = g_stage[STAGES-1].g_tail.ovf_reg;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed and streamed checks of pipe_addsub at 32/8, plus 4/1 exhaustive and 16/16 single-stage.
module tb_pipe_addsub;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;

  logic [31:0] x, y, s;
  logic        c_i, sub, in_valid, in_ready, c_o, ovf, out_valid, out_ready;

  logic [3:0]  x4, y4, s4;
  logic        ci4, sub4, iv4, ir4, co4, ovf4, ov4, or4;

  logic [15:0] x16, y16, s16;
  logic        ci16, sub16, iv16, ir16, co16, ovf16, ov16, or16;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(32), .CHUNK(8)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .y(y), .c_i(c_i), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .s(s), .c_o(c_o), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  pipe_addsub #(.WIDTH(4), .CHUNK(1)) dut4 (
    .clk(clk), .rst_n(rst_n), .x(x4), .y(y4), .c_i(ci4), .sub(sub4),
    .in_valid(iv4), .in_ready(ir4), .s(s4), .c_o(co4), .ovf(ovf4),
    .out_valid(ov4), .out_ready(or4)
  );

  pipe_addsub #(.WIDTH(16), .CHUNK(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .x(x16), .y(y16), .c_i(ci16), .sub(sub16),
    .in_valid(iv16), .in_ready(ir16), .s(s16), .c_o(co16), .ovf(ovf16),
    .out_valid(ov16), .out_ready(or16)
  );

  // Reference {ovf, c_o, s} using the sign rule for overflow.
  function automatic logic [33:0] ref32(input logic [31:0] a, input logic [31:0] b,
                                        input logic ci, input logic sb);
    logic [32:0] t;
    logic [31:0] bb;
    bb = sb ? ~b : b;
    t  = {1'b0, a} + {1'b0, bb} + {32'd0, (sb ? ~ci : ci)};
    return {((a[31] == bb[31]) && (t[31] != a[31])), t[32], t[31:0]};
  endfunction

  // Bit-serial 4-bit ripple model, returns {ovf, c_o, s}.
  function automatic logic [5:0] ripple4(input logic [3:0] a, input logic [3:0] b,
                                         input logic ci, input logic sb);
    logic [3:0] bb, r;
    logic c, cprev;
    bb = sb ? ~b : b;
    c  = sb ? ~ci : ci;
    cprev = 1'b0;
    for (int i = 0; i < 4; i++) begin
      r[i]  = a[i] ^ bb[i] ^ c;
      cprev = c;
      c     = (a[i] & bb[i]) | (c & (a[i] ^ bb[i]));
    end
    return {cprev ^ c, c, r};
  endfunction

  // Drives one beat on the 32-bit instance (called at a negedge) and counts
  // rising edges until the result is visible.
  task automatic beat32(input logic [31:0] a, input logic [31:0] b, input logic ci,
                        input logic sb, output logic [33:0] got, output int lat);
    x = a; y = b; c_i = ci; sub = sb; in_valid = 1'b1; out_ready = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      in_valid = 1'b0;
    end while (!out_valid && lat < 12);
    got = {ovf, c_o, s};
    $display("beat x=%h y=%h ci=%0b sub=%0b -> s=%h c_o=%0b ovf=%0b lat=%0d",
             a, b, ci, sb, got[31:0], got[32], got[33], lat);
  endtask

  task automatic test_reset;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if (s !== 32'h0) begin bad++; $display("FAIL reset_s got=%h exp=00000000", s); end
    total++; if ({c_o, ovf} !== 2'b00) begin bad++; $display("FAIL reset_co_ovf got=%b exp=00", {c_o, ovf}); end
    total++; if ({ov4, ov16} !== 2'b00) begin bad++; $display("FAIL reset_sweep_valid got=%b exp=00", {ov4, ov16}); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    $display("reset checked");
  endtask

  task automatic test_carry_ripple;
    logic [33:0] got;
    int lat;
    @(negedge clk);
    beat32(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, got, lat);
    total++; if (got[31:0] !== 32'h0) begin bad++; $display("FAIL carry_s got=%h exp=00000000", got[31:0]); end
    total++; if (got[32] !== 1'b1) begin bad++; $display("FAIL carry_co got=%b exp=1", got[32]); end
    total++; if (got[33] !== 1'b0) begin bad++; $display("FAIL carry_ovf got=%b exp=0", got[33]); end
    total++; if (lat != 4) begin bad++; $display("FAIL carry_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_overflow;
    logic [31:0] vx [2] = '{32'h7FFFFFFF, 32'h80000000};
    logic [31:0] vs [2] = '{32'h80000000, 32'h7FFFFFFF};
    logic        vsub [2] = '{1'b0, 1'b1};
    logic        vco [2] = '{1'b0, 1'b1};
    logic [33:0] got;
    int lat;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      beat32(vx[i], 32'h00000001, 1'b0, vsub[i], got, lat);
      total++; if (got[31:0] !== vs[i]) begin bad++; $display("FAIL ovf_s[%0d] got=%h exp=%h", i, got[31:0], vs[i]); end
      total++; if (got[32] !== vco[i]) begin bad++; $display("FAIL ovf_co[%0d] got=%b exp=%b", i, got[32], vco[i]); end
      total++; if (got[33] !== 1'b1) begin bad++; $display("FAIL ovf_flag[%0d] got=%b exp=1", i, got[33]); end
      total++; if (lat != 4) begin bad++; $display("FAIL ovf_latency[%0d] got=%0d exp=4", i, lat); end
    end
  endtask

  task automatic test_subtract;
    logic [31:0] vx [2] = '{32'd5, 32'd7};
    logic [31:0] vy [2] = '{32'd7, 32'd5};
    logic        vci [2] = '{1'b1, 1'b0};
    logic [31:0] vs [2] = '{32'hFFFFFFFD, 32'h00000002};
    logic        vco [2] = '{1'b0, 1'b1};
    logic [33:0] got;
    int lat;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      beat32(vx[i], vy[i], vci[i], 1'b1, got, lat);
      total++; if (got[31:0] !== vs[i]) begin bad++; $display("FAIL sub_s[%0d] got=%h exp=%h", i, got[31:0], vs[i]); end
      total++; if (got[32] !== vco[i]) begin bad++; $display("FAIL sub_co[%0d] got=%b exp=%b", i, got[32], vco[i]); end
      total++; if (got[33] !== 1'b0) begin bad++; $display("FAIL sub_ovf[%0d] got=%b exp=0", i, got[33]); end
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] ax [16];
    logic [31:0] ay [16];
    logic        aci [16];
    logic        asub [16];
    logic [33:0] q [$];
    logic [33:0] exp_v;
    logic [33:0] last_out;
    logic        last_stall;
    int idx, got, cyc;
    for (int i = 0; i < 16; i++) begin
      ax[i] = $urandom; ay[i] = $urandom;
      aci[i] = 1'($urandom_range(0, 1)); asub[i] = 1'($urandom_range(0, 1));
    end
    idx = 0; got = 0; cyc = 0; last_stall = 1'b0; last_out = '0;
    while (got < 16 && cyc < 500) begin
      @(negedge clk);
      if (idx < 16) begin
        in_valid = 1'b1; x = ax[idx]; y = ay[idx]; c_i = aci[idx]; sub = asub[idx];
      end else begin
        in_valid = 1'b0;
      end
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      total++; if (in_ready !== !(out_valid && !out_ready)) begin
        bad++; $display("FAIL stream_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, !(out_valid && !out_ready));
      end
      if (last_stall) begin
        total++; if ({ovf, c_o, s} !== last_out || out_valid !== 1'b1) begin
          bad++; $display("FAIL stream_stall_hold cyc=%0d got=%h exp=%h", cyc, {ovf, c_o, s}, last_out);
        end
      end
      last_stall = out_valid && !out_ready;
      last_out   = {ovf, c_o, s};
      if (out_valid && out_ready) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL stream_spurious cyc=%0d got=%h exp=none", cyc, {ovf, c_o, s});
        end else begin
          exp_v = q.pop_front();
          if ({ovf, c_o, s} !== exp_v) begin
            bad++; $display("FAIL stream_result[%0d] got=%h exp=%h", got, {ovf, c_o, s}, exp_v);
          end
          $display("stream out[%0d] s=%h c_o=%0b ovf=%0b", got, s, c_o, ovf);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        q.push_back(ref32(x, y, c_i, sub));
        idx++;
      end
      cyc++;
    end
    total++; if (got != 16) begin bad++; $display("FAIL stream_count got=%0d exp=16", got); end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  task automatic test_reset_midflight;
    logic [33:0] got;
    int n, lat;
    logic seen;
    @(negedge clk);
    out_ready = 1'b1; c_i = 1'b0; sub = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1; x = 32'(k + 1); y = 32'd100;
      @(negedge clk);
    end
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 10) begin @(negedge clk); n++; end
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL midrst_first_valid got=%b exp=1", out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%b exp=0", out_valid); end
    total++; if (s !== 32'h0) begin bad++; $display("FAIL midrst_s got=%h exp=00000000", s); end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (8) begin @(negedge clk); if (out_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL midrst_stale got=%b exp=0", seen); end
    $display("midflight reset: in-flight beats discarded");
    beat32(32'd3, 32'd4, 1'b0, 1'b0, got, lat);
    total++; if (got !== {2'b00, 32'd7}) begin bad++; $display("FAIL midrst_new_beat got=%h exp=%h", got, {2'b00, 32'd7}); end
    total++; if (lat != 4) begin bad++; $display("FAIL midrst_latency got=%0d exp=4", lat); end
  endtask

  task automatic test_sweep_w4;
    logic [5:0] q [$];
    int tq [$];
    logic [5:0] exp_v;
    int idx, got, cyc, t;
    idx = 0; got = 0; cyc = 0;
    or4 = 1'b1;
    while (got < 1024 && cyc < 1200) begin
      @(negedge clk);
      if (idx < 1024) begin
        iv4 = 1'b1; {sub4, ci4, y4, x4} = idx[9:0];
      end else begin
        iv4 = 1'b0;
      end
      #1;
      if (ov4) begin
        total++;
        if (q.size() == 0) begin
          bad++; $display("FAIL w4_spurious cyc=%0d got=%b exp=none", cyc, {ovf4, co4, s4});
        end else begin
          exp_v = q.pop_front();
          t = tq.pop_front();
          if ({ovf4, co4, s4} !== exp_v) begin
            bad++; $display("FAIL w4_result[%0d] got=%b exp=%b", got, {ovf4, co4, s4}, exp_v);
          end
          total++; if (cyc - t != 4) begin bad++; $display("FAIL w4_latency[%0d] got=%0d exp=4", got, cyc - t); end
          $display("w4 out[%0d] s=%h c_o=%0b ovf=%0b", got, s4, co4, ovf4);
        end
        got++;
      end
      if (iv4 && ir4) begin
        q.push_back(ripple4(x4, y4, ci4, sub4));
        tq.push_back(cyc);
        idx++;
      end
      cyc++;
    end
    total++; if (got != 1024) begin bad++; $display("FAIL w4_count got=%0d exp=1024", got); end
    iv4 = 1'b0;
  endtask

  task automatic test_sweep_w16;
    logic [15:0] vx [3] = '{16'hFFFF, 16'h8000, 16'h1234};
    logic [15:0] vy [3] = '{16'h0001, 16'h0001, 16'h0001};
    logic        vci [3] = '{1'b0, 1'b0, 1'b1};
    logic        vsub [3] = '{1'b0, 1'b1, 1'b0};
    logic [17:0] vexp [3] = '{{2'b01, 16'h0000}, {2'b11, 16'h7FFF}, {2'b00, 16'h1236}};
    int lat;
    or16 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      x16 = vx[i]; y16 = vy[i]; ci16 = vci[i]; sub16 = vsub[i]; iv16 = 1'b1;
      lat = 0;
      do begin
        @(posedge clk);
        lat++;
        @(negedge clk);
        iv16 = 1'b0;
      end while (!ov16 && lat < 6);
      $display("w16 beat x=%h y=%h -> s=%h c_o=%0b ovf=%0b lat=%0d", vx[i], vy[i], s16, co16, ovf16, lat);
      total++; if ({ovf16, co16, s16} !== vexp[i]) begin bad++; $display("FAIL w16_result[%0d] got=%h exp=%h", i, {ovf16, co16, s16}, vexp[i]); end
      total++; if (lat != 1) begin bad++; $display("FAIL w16_latency[%0d] got=%0d exp=1", i, lat); end
    end
  endtask

  initial begin
    x = '0; y = '0; c_i = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    x4 = '0; y4 = '0; ci4 = 1'b0; sub4 = 1'b0; iv4 = 1'b0; or4 = 1'b1;
    x16 = '0; y16 = '0; ci16 = 1'b0; sub16 = 1'b0; iv16 = 1'b0; or16 = 1'b1;
    test_reset();
    test_carry_ripple();
    test_overflow();
    test_subtract();
    test_back_to_back();
    test_reset_midflight();
    test_sweep_w4();
    test_sweep_w16();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
